// File: rtl/ms_timer_sched_if.sv
// Bundles the per-channel timer control and status signals of ms_timer_sched.
// The master drives the tick, start/cancel pulses and durations; the slave
// (the scheduler) returns busy, done and overrun.
interface ms_timer_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  logic               tick_1ms;
  logic [NCH-1:0]     start;
  logic [NCH-1:0]     cancel;
  logic [NCH*W-1:0]   dur;
  logic [NCH-1:0]     busy;
  logic [NCH-1:0]     done;
  logic [NCH-1:0]     overrun;

  modport master (
    output tick_1ms, start, cancel, dur,
    input  busy, done, overrun
  );

  modport slave (
    input  tick_1ms, start, cancel, dur,
    output busy, done, overrun
  );
endinterface

// File: rtl/ms_timer_sched.sv
// Shares one 1 ms tick among NCH countdown timers using a single decrementer.
// Each tick marks every busy channel as pending; a round-robin pointer visits
// one channel per clk and consumes that channel's pending tick. A second tick
// arriving before the first was consumed is dropped and flagged as overrun.
module ms_timer_sched #(
  parameter int NCH = 4,
  parameter int W   = 16
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active-low
  ms_timer_sched_if.slave   bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   cnt_q [NCH];
  logic [W-1:0]   cnt_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] ovr_q,  ovr_d;
  logic [NCH-1:0] svc;
  logic [NCH-1:0] expire;

  // Next-state for the scan pointer and every channel.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    ptr_d  = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
    svc    = '0;
    expire = '0;
    pend_d = pend_q;
    busy_d = busy_q;
    done_d = '0;
    ovr_d  = ovr_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];

      // The shared decrementer serves only the channel under the pointer,
      // and only when no start/cancel is overriding it this clk.
      svc[i]    = (ptr_q == PW'(i)) && busy_q[i] && pend_q[i] &&
                  !bus.start[i] && !bus.cancel[i];
      expire[i] = svc[i] && (cnt_q[i] == W'(1));

      if (bus.start[i]) begin
        // Start wins over everything; a tick in this clk is not counted.
        cnt_d[i]  = bus.dur[i*W +: W];
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
        busy_d[i] = (bus.dur[i*W +: W] != '0);
        done_d[i] = (bus.dur[i*W +: W] == '0);
      end else if (bus.cancel[i]) begin
        // Count is frozen; no expiry is reported for a cancelled run.
        busy_d[i] = 1'b0;
        pend_d[i] = 1'b0;
      end else begin
        if (svc[i]) begin
          cnt_d[i]  = cnt_q[i] - 1'b1;
          pend_d[i] = 1'b0;
          if (expire[i]) begin
            busy_d[i] = 1'b0;
            done_d[i] = 1'b1;
          end
        end
        // A new tick re-arms pend even in the clk its predecessor is served;
        // if the old one is still waiting, the new one is lost.
        if (bus.tick_1ms && busy_q[i] && !expire[i]) begin
          if (pend_q[i] && !svc[i]) begin
            ovr_d[i] = 1'b1;
          end else begin
            pend_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset clears every channel immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      pend_q <= '0;
      busy_q <= '0;
      done_q <= '0;
      ovr_q  <= '0;
      // NOTE: the counters are a handful of flops, not a RAM, so they are
      // reset along with the rest of the state.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;

endmodule
